// File: rtl/mul_digit_io.sv
// Serial decimal operand loader and result streamer around the combinational
// decimal multiplier `mul`: 8 operand digits in, settle, capture, 8 result digits out.
module mul_digit_io #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_digit,
    output logic [31:0] x0,
    output logic [31:0] x1,
    output logic [31:0] x2,
    output logic [31:0] x3,
    output logic [31:0] y0,
    output logic [31:0] y1,
    output logic [31:0] y2,
    output logic [31:0] y3,
    input  logic [31:0] z0,
    input  logic [31:0] z1,
    input  logic [31:0] z2,
    input  logic [31:0] z3,
    input  logic [31:0] z4,
    input  logic [31:0] z5,
    input  logic [31:0] z6,
    input  logic [31:0] z7,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_digit,
    output logic        out_last,
    output logic        busy,
    output logic        err
);
    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_STREAM  = 2'd3;
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

    function automatic logic digit_bad(input logic [3:0] d);
        return (d > 4'd9);
    endfunction

    // Result digits from `mul` are checked as signed values; anything outside 0..9 becomes 4'hF.
    function automatic logic result_bad(input logic [31:0] z);
        return (($signed(z) < 32'sd0) || ($signed(z) > 32'sd9));
    endfunction

    logic [1:0]  state_q, state_d;
    logic [2:0]  k_q, k_d;
    logic [2:0]  j_q, j_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [3:0]  x_q [4];
    logic [3:0]  x_d [4];
    logic [3:0]  y_q [4];
    logic [3:0]  y_d [4];
    logic [3:0]  r_q [8];
    logic [3:0]  r_d [8];
    logic [31:0] z_s [8];
    logic [7:0]  z_bad_s;
    logic        in_bad_s;
    logic [3:0]  in_val_s;

    assign z_s[0] = z0;
    assign z_s[1] = z1;
    assign z_s[2] = z2;
    assign z_s[3] = z3;
    assign z_s[4] = z4;
    assign z_s[5] = z5;
    assign z_s[6] = z6;
    assign z_s[7] = z7;

    // Per-position out-of-range flags for the captured product digits.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            z_bad_s[i] = result_bad(z_s[i]);
        end
    end

    assign in_bad_s = digit_bad(in_digit);
    assign in_val_s = in_bad_s ? 4'd0 : in_digit;

    // Next-state logic for the load / settle / capture / stream sequence.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        j_d     = j_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        x_d     = x_q;
        y_d     = y_q;
        r_d     = r_q;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    // k counts MSB first: k=0 addresses x3, k=4 addresses y3.
                    if (k_q[2]) begin
                        y_d[2'd3 - k_q[1:0]] = in_val_s;
                    end else begin
                        x_d[2'd3 - k_q[1:0]] = in_val_s;
                    end
                    if (in_bad_s) begin
                        err_d = 1'b1;
                    end else if (k_q == 3'd0) begin
                        err_d = 1'b0;
                    end else begin
                        err_d = err_q;
                    end
                    if (k_q == 3'd7) begin
                        k_d     = 3'd0;
                        cnt_d   = SETTLE_INIT;
                        state_d = ST_SETTLE;
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end else begin
                    k_d = k_q;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CAPTURE: begin
                for (int i = 0; i < 8; i++) begin
                    r_d[i] = z_bad_s[i] ? 4'hF : z_s[i][3:0];
                end
                err_d   = err_q | (|z_bad_s);
                j_d     = 3'd7;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (out_ready) begin
                    if (j_q == 3'd0) begin
                        j_d     = 3'd7;
                        state_d = ST_LOAD;
                    end else begin
                        j_d = j_q - 3'd1;
                    end
                end else begin
                    j_d = j_q;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            k_q     <= 3'd0;
            j_q     <= 3'd7;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                x_q[i] <= 4'd0;
                y_q[i] <= 4'd0;
            end
            for (int i = 0; i < 8; i++) begin
                r_q[i] <= 4'd0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
        end
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign busy      = (state_q != ST_LOAD);
    assign out_valid = (state_q == ST_STREAM);
    assign out_digit = out_valid ? r_q[j_q] : 4'd0;
    assign out_last  = out_valid && (j_q == 3'd0);
    assign err       = err_q;

    assign x0 = {28'd0, x_q[0]};
    assign x1 = {28'd0, x_q[1]};
    assign x2 = {28'd0, x_q[2]};
    assign x3 = {28'd0, x_q[3]};
    assign y0 = {28'd0, y_q[0]};
    assign y1 = {28'd0, y_q[1]};
    assign y2 = {28'd0, y_q[2]};
    assign y3 = {28'd0, y_q[3]};
endmodule

// File: tb/tb_mul_digit_io.sv
// Scoreboard bench for mul_digit_io: a behavioural `mul` stub, randomized operand
// streams with gaps and back-pressure, and an independent output monitor.
module tb_mul_digit_io;
    localparam int SETTLE = 2;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_digit;
    logic [31:0] x0, x1, x2, x3, y0, y1, y2, y3;
    logic [31:0] z0, z1, z2, z3, z4, z5, z6, z7;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_digit;
    logic        out_last;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_fail = 0;
    int acc_cnt = 0;
    int bp_mode = 0;
    int pat = 0;
    bit err_model = 1'b0;
    bit force_z3 = 1'b0;
    logic [4:0] exp_q[$];
    logic [31:0] px, py, pp;

    mul_digit_io #(.SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_digit(in_digit),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .z0(z0), .z1(z1), .z2(z2), .z3(z3), .z4(z4), .z5(z5), .z6(z6), .z7(z7),
        .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
        .out_last(out_last), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural decimal multiplier; force_z3 models a faulty `mul` driving 10 on z3.
    always_comb begin
        px = x3 * 32'd1000 + x2 * 32'd100 + x1 * 32'd10 + x0;
        py = y3 * 32'd1000 + y2 * 32'd100 + y1 * 32'd10 + y0;
        pp = px * py;
        z0 = pp % 32'd10;
        z1 = (pp / 32'd10) % 32'd10;
        z2 = (pp / 32'd100) % 32'd10;
        z3 = force_z3 ? 32'd10 : (pp / 32'd1000) % 32'd10;
        z4 = (pp / 32'd10000) % 32'd10;
        z5 = (pp / 32'd100000) % 32'd10;
        z6 = (pp / 32'd1000000) % 32'd10;
        z7 = (pp / 32'd10000000) % 32'd10;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Consumer back-pressure: always ready, 1,0,0,1 pattern, or random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                1: begin
                    out_ready = (pat == 0) || (pat == 3);
                    pat = (pat + 1) % 4;
                end
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compares each presented output digit with the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_q.size() > 0) begin
                check("in_ready_low_while_busy", in_ready, 0);
                check("busy_high", busy, 1);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", out_valid, 0);
                end else begin
                    check("out_digit", out_digit, exp_q[0][3:0]);
                    check("out_last", out_last, exp_q[0][4]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        acc_cnt++;
                    end
                end
            end
        end
    end

    task automatic load_digits(input logic [31:0] d, input bit gaps);
        int i;
        int guard;
        bit take;
        bit pend;
        logic [3:0] dig;
        i = 0;
        guard = 0;
        pend = 1'b0;
        while (i < 8 && guard < 400) begin
            @(negedge clk);
            guard++;
            if (pend) check("err_during_load", err, err_model);
            pend = 1'b0;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_digit = d[31-4*i -: 4];
            end
            take = in_valid && in_ready;
            @(posedge clk);
            if (take) begin
                dig = d[31-4*i -: 4];
                if (dig > 4'd9) err_model = 1'b1;
                else if (i == 0) err_model = 1'b0;
                i++;
                pend = 1'b1;
            end
        end
        #1 in_valid = 1'b0;
        if (i < 8) check("load_timeout", i, 8);
    endtask

    task automatic start_product(input logic [31:0] d, input bit gaps, input bit force3);
        logic [31:0] san;
        logic [3:0] dig;
        int xv, yv, pv;
        int dg[8];
        force_z3 = force3;
        san = 32'd0;
        xv = 0;
        yv = 0;
        for (int i = 0; i < 8; i++) begin
            dig = d[31-4*i -: 4];
            if (dig > 4'd9) dig = 4'd0;
            san[31-4*i -: 4] = dig;
            if (i < 4) xv = xv * 10 + int'(dig);
            else yv = yv * 10 + int'(dig);
        end
        pv = xv * yv;
        for (int p = 0; p < 8; p++) begin
            dg[p] = pv % 10;
            pv = pv / 10;
        end
        load_digits(d, gaps);
        for (int p = 7; p >= 0; p--) begin
            exp_q.push_back({(p == 0), (force3 && p == 3) ? 4'hF : 4'(dg[p])});
        end
        check("xy_regs", {x3[3:0], x2[3:0], x1[3:0], x0[3:0], y3[3:0], y2[3:0], y1[3:0], y0[3:0]}, san);
        check("xy_zero_ext", {4'd0, x3[31:4] | x2[31:4] | x1[31:4] | x0[31:4] | y3[31:4] | y2[31:4] | y1[31:4] | y0[31:4]}, 0);
        for (int c = 1; c <= SETTLE + 2; c++) begin
            @(negedge clk);
            if (c == 1) check("err_after_load", err, err_model);
            if (c < SETTLE + 2) check("out_valid_before_stream", out_valid, 0);
            else check("first_out_valid_latency", out_valid, 1);
        end
        if (force3) err_model = 1'b1;
    endtask

    task automatic finish_product();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 400) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) check("stream_timeout", exp_q.size(), 0);
        @(negedge clk);
        check("in_ready_after_last", in_ready, 1);
        check("out_valid_after_last", out_valid, 0);
        check("err_after_stream", err, err_model);
        force_z3 = 1'b0;
    endtask

    task automatic run_product(input logic [31:0] d, input bit gaps, input bit force3, input int bp);
        bp_mode = bp;
        start_product(d, gaps, force3);
        finish_product();
        bp_mode = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_out_digit"}, out_digit, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_xy"}, x0 | x1 | x2 | x3 | y0 | y1 | y2 | y3, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int guard;
        logic [31:0] d;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_digit = 4'd0;
        #1;
        check_reset_state("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_product(32'h1234_5678, 1'b0, 1'b0, 0);
        run_product(32'h9999_9999, 1'b0, 1'b0, 0);
        run_product(32'h1234_5678, 1'b1, 1'b0, 1);
        run_product(32'h1C00_0002, 1'b0, 1'b0, 0);
        run_product(32'h1234_5678, 1'b0, 1'b1, 0);
        run_product(32'h2468_1357, 1'b1, 1'b0, 2);

        // Reset after three result digits have been accepted.
        base = acc_cnt;
        bp_mode = 0;
        start_product(32'h1234_5678, 1'b0, 1'b0);
        guard = 0;
        while (acc_cnt < base + 3 && guard < 300) begin
            @(posedge clk);
            guard++;
        end
        if (acc_cnt < base + 3) check("midreset_wait_timeout", acc_cnt, base + 3);
        #2 rst_n = 1'b0;
        exp_q.delete();
        err_model = 1'b0;
        force_z3 = 1'b0;
        #1;
        check_reset_state("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_product(32'h1234_5678, 1'b0, 1'b0, 0);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 15) == 0) d[31-4*i -: 4] = 4'($urandom_range(10, 15));
                else d[31-4*i -: 4] = 4'($urandom_range(0, 9));
            end
            run_product(d, 1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
